// File: rtl/wb_burst_master.sv
// wb_burst_master
//
// Wishbone classic burst master. A burst request (start address, beats-1)
// is taken over a valid/ready command port. The master then issues one
// Wishbone beat per address with an incrementing address. It waits for ACK
// on each beat, and it can insert a fixed number of idle cycles between
// beats. If a beat receives no ACK for TIMEOUT cycles, the cycle is
// aborted and err pulses.
//
// Parameters
//   ADDR_W      width of ADR / req_addr
//   LEN_W       width of req_len (burst = req_len+1 beats)
//   ADDR_INC    address increment per beat (wraps modulo 2^ADDR_W)
//   GAP_CYCLES  idle cycles (CYC=1, STB=0) between beats of a burst (0..15)
//   TIMEOUT     max STB cycles without ACK before the cycle is aborted (>=1)
//
// Ports
//   CLK, RST             clock; asynchronous active-high reset
//   req_valid/req_ready  burst command handshake
//   req_addr, req_len    burst start address and beat count minus one
//   CYC, STB, ADR, ACK   Wishbone master signals
//   done                 one-cycle pulse: burst finished normally
//   err                  one-cycle pulse: burst aborted on ACK timeout
//   beats_done           beats acknowledged in the current/last burst

module wb_burst_master #(
  parameter int ADDR_W     = 32,
  parameter int LEN_W      = 8,
  parameter int ADDR_INC   = 4,
  parameter int GAP_CYCLES = 0,
  parameter int TIMEOUT    = 16
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [LEN_W-1:0]  req_len,
  output logic              CYC,
  output logic              STB,
  output logic [ADDR_W-1:0] ADR,
  input  logic              ACK,
  output logic              done,
  output logic              err,
  output logic [LEN_W:0]    beats_done
);

  // The wait counter holds the number of STB cycles already spent without
  // ACK on the current beat, so it only needs to reach TIMEOUT-1.
  localparam int WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);
  localparam logic [3:0]        GAP_LAST  = (GAP_CYCLES > 0) ? 4'(GAP_CYCLES - 1) : 4'd0;
  localparam logic [ADDR_W-1:0] INC       = ADDR_W'(ADDR_INC);
  localparam logic [LEN_W:0]    BEAT_ONE  = (LEN_W+1)'(1);
  localparam logic [LEN_W-1:0]  LEN_ONE   = LEN_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STROBE = 2'd1,
    ST_GAP    = 2'd2,
    ST_END    = 2'd3
  } state_t;

  state_t              state_reg,  state_next;
  logic [ADDR_W-1:0]   addr_reg,   addr_next;
  logic [LEN_W-1:0]    remain_reg, remain_next;  // beats left after the current one
  logic [LEN_W:0]      beats_reg,  beats_next;
  logic [WAIT_W-1:0]   wait_reg,   wait_next;
  logic [3:0]          gap_reg,    gap_next;
  logic                err_reg,    err_next;
  logic                accept;

  // Ready is forced low while reset is held, so nothing is accepted in the
  // same cycle the master is coming out of reset.
  assign req_ready = ((state_reg == ST_IDLE) || (state_reg == ST_END)) && !RST;
  assign accept    = req_valid && req_ready;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_reg  <= ST_IDLE;
      addr_reg   <= '0;
      remain_reg <= '0;
      beats_reg  <= '0;
      wait_reg   <= '0;
      gap_reg    <= '0;
      err_reg    <= 1'b0;
    end else begin
      state_reg  <= state_next;
      addr_reg   <= addr_next;
      remain_reg <= remain_next;
      beats_reg  <= beats_next;
      wait_reg   <= wait_next;
      gap_reg    <= gap_next;
      err_reg    <= err_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    addr_next   = addr_reg;
    remain_next = remain_reg;
    beats_next  = beats_reg;
    wait_next   = wait_reg;
    gap_next    = gap_reg;
    err_next    = 1'b0;

    case (state_reg)
      // END behaves like IDLE for the command port. This allows a new burst
      // to start right after the done cycle, with only one cycle of CYC low.
      ST_IDLE, ST_END: begin
        if (accept) begin
          addr_next   = req_addr;
          remain_next = req_len;
          beats_next  = '0;
          wait_next   = '0;
          state_next  = ST_STROBE;
        end else begin
          state_next  = ST_IDLE;
        end
      end

      ST_STROBE: begin
        // ACK is checked first, so an ACK in the expiry cycle still
        // completes the beat.
        if (ACK) begin
          beats_next = beats_reg + BEAT_ONE;
          wait_next  = '0;
          if (remain_reg == '0) begin
            state_next = ST_END;
          end else begin
            remain_next = remain_reg - LEN_ONE;
            addr_next   = addr_reg + INC;
            if (GAP_CYCLES > 0) begin
              gap_next   = '0;
              state_next = ST_GAP;
            end
          end
        end else if (wait_reg == WAIT_LAST) begin
          err_next   = 1'b1;
          state_next = ST_IDLE;
        end else begin
          wait_next = wait_reg + 1'b1;
        end
      end

      ST_GAP: begin
        // ACK is ignored here. CYC stays high, so the bus cycle is kept.
        if (gap_reg == GAP_LAST) begin
          wait_next  = '0;
          state_next = ST_STROBE;
        end else begin
          gap_next = gap_reg + 1'b1;
        end
      end

      default: state_next = ST_IDLE;
    endcase
  end

  // All bus outputs are decoded from registers. This means no ACK-to-output
  // combinational path exists, and reset clears them immediately.
  assign CYC        = (state_reg == ST_STROBE) || (state_reg == ST_GAP);
  assign STB        = (state_reg == ST_STROBE);
  assign ADR        = addr_reg;
  assign done       = (state_reg == ST_END);
  assign err        = err_reg;
  assign beats_done = beats_reg;

endmodule

// File: tb/tb_wb_burst_master.sv
module tb_wb_burst_master;

  // Two instances: dut 0 = no gap / TIMEOUT 16, dut 1 = gap 2 / TIMEOUT 4
  int gap_cfg [2] = '{0, 2};
  int tmo_cfg [2] = '{16, 4};

  logic        clk;
  logic        rst       [2];
  logic        req_valid [2];
  logic        req_ready [2];
  logic [31:0] req_addr  [2];
  logic [7:0]  req_len   [2];
  logic        cyc       [2];
  logic        stb       [2];
  logic [31:0] adr       [2];
  logic        ack       [2];
  logic        done      [2];
  logic        err       [2];
  logic [8:0]  beats_done[2];

  wb_burst_master #(.ADDR_W(32), .LEN_W(8), .ADDR_INC(4), .GAP_CYCLES(0), .TIMEOUT(16)) dut_a (
    .CLK(clk), .RST(rst[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_addr(req_addr[0]), .req_len(req_len[0]), .CYC(cyc[0]), .STB(stb[0]),
    .ADR(adr[0]), .ACK(ack[0]), .done(done[0]), .err(err[0]), .beats_done(beats_done[0]));

  wb_burst_master #(.ADDR_W(32), .LEN_W(8), .ADDR_INC(4), .GAP_CYCLES(2), .TIMEOUT(4)) dut_b (
    .CLK(clk), .RST(rst[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_addr(req_addr[1]), .req_len(req_len[1]), .CYC(cyc[1]), .STB(stb[1]),
    .ADR(adr[1]), .ACK(ack[1]), .done(done[1]), .err(err[1]), .beats_done(beats_done[1]));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_checks++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, expv);
  endtask

  // Expected per-cycle bus picture: flags = {CYC, STB, req_ready, done, err}
  typedef struct {
    logic [4:0]  flags;
    logic        ack;
    logic [31:0] adr;
    int          bd;     // expected beats_done, -1 = do not check
  } exp_t;

  typedef struct {
    int          d;
    logic [31:0] addr;
    int          len;
    int          w;       // wait states on every beat
    int          hang;    // beat index that never gets ACK, -1 = none
    logic        gap_ack; // drive ACK during gap cycles
    int          exp_bd;
    int          exp_done;
    int          exp_err;
  } vec_t;

  exp_t eq[$];
  int   beat_wait[256];

  // The expected trace follows the timing rules directly. Accepting takes
  // 1 cycle. Each beat takes min(W+1, TIMEOUT) STB cycles. A hung beat is
  // followed by one err cycle. Otherwise G gap cycles come between beats,
  // and a done cycle comes after the last beat.
  task automatic run_burst(input int d, input logic [31:0] a, input int len, input logic gap_ack,
                           output int model_bd, output int model_done, output int model_err,
                           output int dut_done, output int dut_err);
    exp_t        r;
    int          bd;
    int          w;
    int          stb_cycles;
    logic        hung;
    logic [31:0] ba;
    eq.delete();
    model_done = 0;
    model_err  = 0;
    r.flags = 5'b00100; r.ack = 1'($urandom_range(0, 1)); r.adr = '0; r.bd = -1;
    eq.push_back(r);
    bd = 0;
    for (int i = 0; i <= len; i++) begin
      ba = a + 32'(i) * 32'd4;
      w = beat_wait[i];
      hung = (w >= tmo_cfg[d]);
      stb_cycles = hung ? tmo_cfg[d] : w + 1;
      for (int c = 0; c < stb_cycles; c++) begin
        r.flags = 5'b11000; r.adr = ba; r.bd = bd;
        r.ack = !hung && (c == stb_cycles - 1);
        eq.push_back(r);
      end
      if (hung) begin
        r.flags = 5'b00101; r.ack = 1'b0; r.bd = bd; r.adr = '0;
        eq.push_back(r);
        model_err = 1;
        break;
      end
      bd++;
      if (i == len) begin
        r.flags = 5'b00110; r.ack = 1'b0; r.bd = bd; r.adr = '0;
        eq.push_back(r);
        model_done = 1;
      end else begin
        for (int g = 0; g < gap_cfg[d]; g++) begin
          r.flags = 5'b10000; r.ack = gap_ack; r.bd = bd; r.adr = '0;
          eq.push_back(r);
        end
      end
    end
    model_bd = bd;

    dut_done = 0;
    dut_err  = 0;
    for (int k = 0; k < eq.size(); k++) begin
      r = eq[k];
      @(negedge clk);
      check("bus_flags", {cyc[d], stb[d], req_ready[d], done[d], err[d]}, r.flags);
      if (r.flags[3]) check("adr", adr[d], r.adr);
      if (r.bd >= 0) check("beats_done", beats_done[d], 64'(r.bd));
      if (done[d]) dut_done++;
      if (err[d]) dut_err++;
      req_valid[d] = (k == 0);
      if (k == 0) begin
        req_addr[d] = a;
        req_len[d]  = 8'(len);
      end
      ack[d] = r.ack;
    end
    req_valid[d] = 1'b0;
    ack[d] = 1'b0;
  endtask

  // Runs one burst, then checks the idle cycle that follows it.
  task automatic do_txn(input int d, input logic [31:0] a, input int len, input logic gap_ack,
                        input int use_model, input int t_bd, input int t_done, input int t_err);
    int m_bd, m_done, m_err, o_done, o_err;
    int e_bd, e_done, e_err;
    run_burst(d, a, len, gap_ack, m_bd, m_done, m_err, o_done, o_err);
    e_bd   = use_model ? m_bd   : t_bd;
    e_done = use_model ? m_done : t_done;
    e_err  = use_model ? m_err  : t_err;
    @(negedge clk);
    check("idle_after", {cyc[d], stb[d], req_ready[d], done[d], err[d]}, 5'b00100);
    check("final_beats", beats_done[d], 64'(e_bd));
    check("done_pulses", 64'(o_done), 64'(e_done));
    check("err_pulses", 64'(o_err), 64'(e_err));
    $display("burst dut=%0d addr=%08h len=%0d beats=%0d done=%0d err=%0d",
             d, a, len, beats_done[d], o_done, o_err);
  endtask

  task automatic chk_bus(input int d, input string name, input logic [4:0] f,
                         input logic [31:0] a, input logic chk_a);
    check(name, {cyc[d], stb[d], req_ready[d], done[d], err[d]}, f);
    if (chk_a) check({name, "_adr"}, adr[d], a);
  endtask

  vec_t tbl[8];

  initial begin
    tbl[0] = '{d:0, addr:32'h0000_0100, len:0, w:0, hang:-1, gap_ack:1'b0, exp_bd:1, exp_done:1, exp_err:0};
    tbl[1] = '{d:0, addr:32'h0000_1000, len:3, w:0, hang:-1, gap_ack:1'b0, exp_bd:4, exp_done:1, exp_err:0};
    tbl[2] = '{d:1, addr:32'h0000_2000, len:1, w:2, hang:-1, gap_ack:1'b1, exp_bd:2, exp_done:1, exp_err:0};
    tbl[3] = '{d:1, addr:32'h0000_3000, len:2, w:0, hang:1,  gap_ack:1'b0, exp_bd:1, exp_done:0, exp_err:1};
    tbl[4] = '{d:1, addr:32'h0000_3100, len:2, w:3, hang:-1, gap_ack:1'b0, exp_bd:3, exp_done:1, exp_err:0};
    tbl[5] = '{d:0, addr:32'hFFFF_FFFC, len:1, w:0, hang:-1, gap_ack:1'b0, exp_bd:2, exp_done:1, exp_err:0};
    tbl[6] = '{d:0, addr:32'h0000_5000, len:0, w:0, hang:0,  gap_ack:1'b0, exp_bd:0, exp_done:0, exp_err:1};
    tbl[7] = '{d:1, addr:32'h0000_6000, len:0, w:4, hang:-1, gap_ack:1'b0, exp_bd:0, exp_done:0, exp_err:1};

    for (int d = 0; d < 2; d++) begin
      rst[d] = 1'b1; req_valid[d] = 1'b0; req_addr[d] = '0; req_len[d] = '0; ack[d] = 1'b0;
    end

    // Reset state while reset is held, then first cycle after release
    repeat (2) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk_bus(d, "reset_hold", 5'b00000, 32'h0, 1'b1);
      check("reset_beats", beats_done[d], 64'h0);
    end
    rst[0] = 1'b0; rst[1] = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) chk_bus(d, "reset_release", 5'b00100, 32'h0, 1'b0);

    // Directed table
    for (int t = 0; t < 8; t++) begin
      for (int i = 0; i < 256; i++) beat_wait[i] = (i == tbl[t].hang) ? 1000 : tbl[t].w;
      do_txn(tbl[t].d, tbl[t].addr, tbl[t].len, tbl[t].gap_ack, 0,
             tbl[t].exp_bd, tbl[t].exp_done, tbl[t].exp_err);
    end

    // Randomized bursts against the trace model, with ACK noise while idle
    for (int n = 0; n < 40; n++) begin
      int d;
      int len;
      d = int'($urandom_range(0, 1));
      len = int'($urandom_range(0, 5));
      for (int i = 0; i <= len; i++) begin
        if ($urandom_range(0, 7) == 0)
          beat_wait[i] = int'($urandom_range(32'(tmo_cfg[d]), 32'(tmo_cfg[d] + 2)));
        else
          beat_wait[i] = int'($urandom_range(0, 3));
      end
      do_txn(d, $urandom, len, 1'($urandom_range(0, 1)), 1, 0, 0, 0);
      for (int k = 0; k < int'($urandom_range(0, 2)); k++) begin
        ack[d] = 1'($urandom_range(0, 1));
        @(negedge clk);
        chk_bus(d, "idle_noise", 5'b00100, 32'h0, 1'b0);
      end
      ack[d] = 1'b0;
    end

    // Back-to-back bursts on dut 0 with ACK tied high, then reset mid-burst
    @(negedge clk);
    chk_bus(0, "b2b_idle", 5'b00100, 32'h0, 1'b0);
    ack[0] = 1'b1; req_valid[0] = 1'b1; req_addr[0] = 32'h0000_7000; req_len[0] = 8'd1;
    @(negedge clk);
    chk_bus(0, "b2b_a0", 5'b11000, 32'h0000_7000, 1'b1);
    req_valid[0] = 1'b0;
    @(negedge clk);
    chk_bus(0, "b2b_a1", 5'b11000, 32'h0000_7004, 1'b1);
    @(negedge clk);
    chk_bus(0, "b2b_end", 5'b00110, 32'h0, 1'b0);
    check("b2b_beats", beats_done[0], 64'd2);
    req_valid[0] = 1'b1; req_addr[0] = 32'h0000_8000; req_len[0] = 8'd3;
    @(negedge clk);
    chk_bus(0, "b2b_b0", 5'b11000, 32'h0000_8000, 1'b1);
    check("b2b_b_cleared", beats_done[0], 64'd0);
    req_valid[0] = 1'b0;
    @(negedge clk);
    chk_bus(0, "b2b_b1", 5'b11000, 32'h0000_8004, 1'b1);
    #2 rst[0] = 1'b1;
    #1;
    chk_bus(0, "midrst", 5'b00000, 32'h0, 1'b1);
    check("midrst_beats", beats_done[0], 64'd0);
    @(negedge clk);
    chk_bus(0, "midrst_hold", 5'b00000, 32'h0, 1'b1);
    rst[0] = 1'b0;
    #1;
    chk_bus(0, "midrst_release", 5'b00100, 32'h0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk_bus(0, "midrst_discard", 5'b00100, 32'h0, 1'b0);
    end
    ack[0] = 1'b0;
    $display("burst dut=0 back-to-back 0x7000/0x8000 then reset mid-burst");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/wb_burst_master.md
# wb_burst_master

Wishbone classic master that drives CYC/STB/ADR into the bus shared with the SVA master checker and consumes the slave's ACK. It is the stimulus-side stage feeding that checker. It accepts burst requests over a valid/ready command port and issues one Wishbone beat per address. Addresses are incrementing, ACK wait states are honoured, optional idle gaps are inserted between beats, and an ACK timeout aborts a hung cycle. Every bus behaviour it produces must pass the checker's protocol rules by construction.

## Interface
- ADDR_W, 32, width of ADR and req_addr
- LEN_W, 8, width of req_len; burst length is req_len+1 beats (1..2^LEN_W)
- ADDR_INC, 4, address increment per beat
- GAP_CYCLES, 0, idle cycles with STB low and CYC high between beats of one burst (0..15)
- TIMEOUT, 16, maximum cycles STB may stay high without ACK (>=1)

- CLK  in  1  clock; all logic on rising edge
- RST  in  1  asynchronous, active-high reset
- req_valid  in  1  burst request valid
- req_ready  out  1  master can accept a request
- req_addr  in  ADDR_W  start address
- req_len  in  LEN_W  beats minus one
- CYC  out  1  Wishbone cycle
- STB  out  1  Wishbone strobe
- ADR  out  ADDR_W  Wishbone address
- ACK  in  1  slave acknowledge
- done  out  1  one-cycle pulse: burst completed normally
- err  out  1  one-cycle pulse: burst aborted on timeout
- beats_done  out  LEN_W+1  beats acknowledged in the current/last burst

## Operation
- States: IDLE, STROBE (STB=1, waiting ACK), GAP (STB=0, CYC=1), END.
- IDLE: req_ready=1, CYC=STB=0. On req_valid&&req_ready, capture addr/len, clear beats_done, go to STROBE.
- STROBE: CYC=STB=1, ADR=current address. ADR is held stable until ACK is sampled.
  - ACK sampled high: beats_done++.
  - If beats remain: ADR+=ADDR_INC, go to GAP (GAP_CYCLES>0) or stay in STROBE (GAP_CYCLES=0).
  - If last beat: go to END.
- GAP: hold CYC=1, STB=0 for exactly GAP_CYCLES cycles, then STROBE. ACK in GAP is ignored.
- END: CYC=STB=0, done=1 for one cycle, req_ready=1 in this cycle; a request accepted here enters STROBE next cycle. Otherwise go to IDLE.
- Timeout: wait counter resets at each STROBE entry and on each ACK, and increments each STROBE cycle without ACK.
  - If TIMEOUT cycles elapse without ACK: CYC=STB=0 next cycle, err=1 for one cycle, go to IDLE.
  - beats_done keeps the count of acknowledged beats.
- ACK in the same cycle the counter expires: ACK wins, no error.
- Address arithmetic is modulo 2^ADDR_W; it wraps silently past the top.
- ACK while CYC=0 is ignored.
- STB is never high without CYC. CYC is always low for at least one cycle between two bursts.
- done and err are never high together.

## Timing
- Reset values: req_ready=0 during RST, 1 in the first cycle after release. CYC=STB=0, ADR=0, done=err=0, beats_done=0.
- RST asserted mid-burst: CYC/STB drop asynchronously, no done/err, the captured request is discarded.
- Accept to STB high: 1 cycle.
- Zero-wait slave, GAP_CYCLES=0: N beats occupy N consecutive STB cycles; done in cycle N+1 after STB first rises.
- Per beat with W wait states and gap G: W+1 STB cycles, then G gap cycles.
- Minimum request-to-request spacing: N+1 cycles for an N-beat zero-wait burst, with CYC low for one cycle in the END cycle.
- Timeout: err appears TIMEOUT+1 cycles after the STB rise of the stalled beat.

## Test plan
- Single beat, req_addr=0x100, req_len=0, ACK tied high: STB is high one cycle with ADR=0x100; done next cycle; beats_done=1.
- Burst req_addr=0x1000, req_len=3, zero-wait, GAP_CYCLES=0: ADR sequence 0x1000/0x1004/0x1008/0x100C on consecutive cycles; CYC continuous; done once; beats_done=4.
- Burst req_len=1 with 2 wait states per beat, GAP_CYCLES=2: ADR stable for 3 cycles per beat; STB low and CYC high for 2 cycles between beats; ACK injected during the gap is ignored.
- TIMEOUT=4, no ACK on beat 2 of 3: STB high 4 cycles; CYC drops; err pulses; beats_done=1; a second case with ACK on the 4th cycle completes normally.
- req_addr=0xFFFFFFFC, req_len=1: ADR goes 0xFFFFFFFC then 0x00000000.
- Back-to-back requests, then RST asserted mid-burst: CYC low for exactly one cycle between bursts; on RST all outputs return to reset values immediately, with no done or err.
